pe_result_tx: RTL and testbench

- Transmit side of the PE host link: takes 16-bit processing-element results over valid/ready and sends each one as a 4-byte frame on an 8-bit parallel bus.
- The bus uses a 4-phase strobe/ack handshake with the external host (ATE/microcontroller).
- Sits between the PE core and the uo_out/uio pin mapping in tt_um_pe_simonbju.
- Results are buffered in a small FIFO so the PE is not stalled by a slow host.

---
 rtl/pe_link_pkg.sv | 29 ++
 rtl/pe_sync_fifo.sv | 60 ++++++
 rtl/pe_result_tx.sv | 145 ++++++++++++++
 tb/tb_pe_result_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_link_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pe_link_pkg
// Description : Shared types, constants and checksum helper for the PE link.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_LO = 2'd2
    } tx_state_t;

    localparam logic [7:0] c_sync_byte_default = 8'hA5;
    localparam int         c_frame_len         = 4;

    // Frame checksum covers the header byte as well as both payload bytes.
    function automatic logic [7:0] csum8(
        input logic [7:0] msb,
        input logic [7:0] lsb,
        input logic [7:0] sync = c_sync_byte_default
    );
        return sync ^ msb ^ lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pe_sync_fifo
// Description : Single-clock first-word-fall-through FIFO (head valid when !empty).
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_result_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pe_result_tx
// Description : Buffers 16-bit PE results and sends each as a 4-byte frame
//               over an 8-bit strobe/ack (4-phase) link.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_result_tx
    import pe_link_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = c_sync_byte_default
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] res_data,
    input  logic        res_valid,
    output logic        res_ready,
    output logic [7:0]  tx_data,
    output logic        tx_strb,
    input  logic        tx_ack,
    output logic        busy,
    output logic [7:0]  frames_sent
);

    localparam logic [1:0] c_last_idx = 2'(c_frame_len - 1);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic [15:0] r_shd;
    logic [15:0] w_shd_nxt;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;
    logic        r_tx_strb;
    logic        w_tx_strb_nxt;
    logic [7:0]  r_frames;
    logic [7:0]  w_frames_nxt;

    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_head;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] shd);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = shd[15:8];
            2'd2:    b = shd[7:0];
            default: b = csum8(shd[15:8], shd[7:0], SYNC_BYTE);
        endcase
        return b;
    endfunction

    pe_sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (res_valid),
        .i_data  (res_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_shd     <= 16'd0;
            r_tx_data <= 8'd0;
            r_tx_strb <= 1'b0;
            r_frames  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_shd     <= w_shd_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_strb <= w_tx_strb_nxt;
            r_frames  <= w_frames_nxt;
        end
    end

    // tx_data only ever changes together with a rising strobe, so it is stable
    // for the whole strobe-high phase and holds the last byte between bytes.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_shd_nxt     = r_shd;
        w_tx_data_nxt = r_tx_data;
        w_tx_strb_nxt = r_tx_strb;
        w_frames_nxt  = r_frames;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shd_nxt     = w_head;
                    w_idx_nxt     = 2'd0;
                    w_tx_data_nxt = SYNC_BYTE;
                    w_tx_strb_nxt = 1'b1;
                    w_state_nxt   = SEND;
                end
            end
            SEND: begin
                // An ack that is already high here still counts; WAIT_LO
                // re-establishes the handshake by waiting for the low level.
                if (tx_ack) begin
                    w_tx_strb_nxt = 1'b0;
                    w_state_nxt   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_ack) begin
                    if (r_idx != c_last_idx) begin
                        w_idx_nxt     = r_idx + 2'd1;
                        w_tx_data_nxt = frame_byte(r_idx + 2'd1, r_shd);
                        w_tx_strb_nxt = 1'b1;
                        w_state_nxt   = SEND;
                    end else begin
                        w_frames_nxt  = r_frames + 8'd1;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign res_ready   = !w_full;
    assign busy        = (r_state != IDLE) || !w_empty;
    assign tx_data     = r_tx_data;
    assign tx_strb     = r_tx_strb;
    assign frames_sent = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_pe_result_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pe_result_tx
// Description : Self-checking bench for pe_result_tx with a 4-phase host model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_result_tx;

    localparam int         DEPTH = 4;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk;
    logic        rst;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  tx_data;
    logic        tx_strb;
    logic        tx_ack;
    logic        busy;
    logic [7:0]  frames_sent;

    pe_result_tx #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .tx_data     (tx_data),
        .tx_strb     (tx_strb),
        .tx_ack      (tx_ack),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    typedef struct {
        logic [15:0] data;
        int          dly;
        logic [7:0]  csum;
    } vec_t;

    vec_t        vecs[6];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_fs = 8'd0;

    logic        host_auto = 1'b0;
    logic        h_rand = 1'b0;
    int          h_fixed = 0;
    int          h_dly = 0;
    int          h_cnt = 0;
    logic        ack_seen = 1'b0;

    logic        prev_strb = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    int          byte_cnt = 0;
    int          frames_rx = 0;
    logic [7:0]  rx_b[4];
    logic [31:0] last_frame = 32'd0;
    logic [7:0]  csum_lo[256];

    function automatic logic [31:0] model_frame(input logic [15:0] v);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = v[15:8];
        lo = v[7:0];
        return {SYNC, hi, lo, SYNC ^ hi ^ lo};
    endfunction

    function automatic int next_dly();
        return h_rand ? int'($urandom_range(0, 7)) : h_fixed;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Level of tx_ack that the DUT samples at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            ack_seen = tx_ack;
        end
    end

    // Host: raises ack h_dly cycles after seeing the strobe, drops it h_dly
    // cycles after the strobe falls.
    initial begin
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !host_auto) begin
                tx_ack = 1'b0;
                h_cnt  = 0;
            end else if (!tx_ack) begin
                if (tx_strb) begin
                    if (h_cnt >= h_dly) begin
                        tx_ack = 1'b1;
                        h_cnt  = 0;
                        h_dly  = next_dly();
                    end else begin
                        h_cnt++;
                    end
                end
            end else if (!tx_strb) begin
                if (h_cnt >= h_dly) begin
                    tx_ack = 1'b0;
                    h_cnt  = 0;
                    h_dly  = next_dly();
                end else begin
                    h_cnt++;
                end
            end
        end
    end

    // Link monitor: data stability, strobe-after-ack-low, frame assembly.
    initial begin
        logic [15:0] v;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_strb = 1'b0;
                byte_cnt  = 0;
            end else begin
                if (tx_strb && prev_strb) begin
                    check("strb_data_stable", 32'(tx_data), 32'(prev_data));
                end
                if (tx_strb && !prev_strb) begin
                    check("strb_after_ack_low", 32'(ack_seen), 32'd0);
                    rx_b[byte_cnt] = tx_data;
                    byte_cnt++;
                    if (byte_cnt == 4) begin
                        last_frame = {rx_b[0], rx_b[1], rx_b[2], rx_b[3]};
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got 0x%0h, expected none", last_frame);
                        end else begin
                            v = exp_q.pop_front();
                            check("frame_vs_model", last_frame, model_frame(v));
                        end
                        if (rx_b[1] == 8'd0) begin
                            csum_lo[rx_b[2]] = rx_b[3];
                        end
                        frames_rx++;
                        byte_cnt = 0;
                    end
                end
                prev_strb = tx_strb;
                prev_data = tx_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input logic [15:0] v);
        int w;
        w = 0;
        res_valid = 1'b1;
        res_data  = v;
        while (!res_ready && w < 400) begin
            tick();
            w++;
        end
        if (res_ready) begin
            exp_q.push_back(v);
            exp_fs = exp_fs + 8'd1;
        end else begin
            check("push_timeout", 32'(res_ready), 32'd1);
        end
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int w;
        w = 0;
        while ((busy || exp_q.size() != 0) && w < max) begin
            tick();
            w++;
        end
        check("drain_timeout", 32'(w < max), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_fs = 8'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          accepted;
        int          fr0;
        int          w;
        logic [15:0] vals[6];

        vecs[0] = '{16'h1234, 2, 8'h83};
        vecs[1] = '{16'hBEEF, 0, 8'hF4};
        vecs[2] = '{16'h00A5, 1, 8'h00};
        vecs[3] = '{16'hFFFF, 3, 8'hA5};
        vecs[4] = '{16'h0000, 0, 8'hA5};
        vecs[5] = '{16'h8001, 5, 8'h24};

        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = 16'd0;
        repeat (3) tick();

        // Reset values
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_strb", 32'(tx_strb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_ready", 32'(res_ready), 32'd1);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_tx_strb", 32'(tx_strb), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_res_ready", 32'(res_ready), 32'd1);
            check("idle_frames_sent", 32'(frames_sent), 32'd0);
        end

        // Single frames from the vector table
        host_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            h_fixed = vecs[i].dly;
            push_val(vecs[i].data);
            wait_idle(300);
            check("vec_frame", last_frame, {SYNC, vecs[i].data, vecs[i].csum});
            check("vec_frames_sent", 32'(frames_sent), 32'(i + 1));
            check("vec_busy_low", 32'(busy), 32'd0);
        end

        // Backpressure: host silent, six pushes
        host_auto = 1'b0;
        for (int i = 0; i < 6; i++) vals[i] = 16'hC000 + 16'(i * 16'h0111);
        accepted  = 0;
        res_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            res_data = vals[accepted < 6 ? accepted : 5];
            if (res_ready && accepted < 6) begin
                exp_q.push_back(res_data);
                exp_fs = exp_fs + 8'd1;
                accepted++;
            end
            tick();
        end
        // One result is held in the frame shadow, DEPTH more in the FIFO.
        check("bp_accepted", 32'(accepted), 32'(DEPTH + 1));
        check("bp_res_ready_low", 32'(res_ready), 32'd0);
        check("bp_strb_held", 32'(tx_strb), 32'd1);
        check("bp_data_sync", 32'(tx_data), 32'(SYNC));
        check("bp_busy", 32'(busy), 32'd1);
        host_auto = 1'b1;
        h_rand    = 1'b1;
        w = 0;
        while (accepted < 6 && w < 400) begin
            res_data = vals[accepted];
            if (res_ready) begin
                exp_q.push_back(res_data);
                exp_fs = exp_fs + 8'd1;
                accepted++;
            end
            tick();
            w++;
        end
        res_valid = 1'b0;
        check("bp_all_accepted", 32'(accepted), 32'd6);
        wait_idle(2000);
        check("bp_frames_sent", 32'(frames_sent), 32'(exp_fs));

        // Random traffic with random ack delays
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push_val(16'($urandom));
        end
        wait_idle(5000);
        check("rand_frames_sent", 32'(frames_sent), 32'(exp_fs));

        // Reset during byte-2 strobe with frames queued
        h_rand  = 1'b0;
        h_fixed = 3;
        push_val(16'h00FF);
        push_val(16'h1111);
        push_val(16'h2222);
        w = 0;
        while (!(byte_cnt == 3 && tx_strb) && w < 200) begin
            tick();
            w++;
        end
        check("mid_reset_reached_byte2", 32'(w < 200), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        exp_fs = 8'd0;
        tick();
        rst = 1'b0;
        check("mid_reset_strb", 32'(tx_strb), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_frames_sent", 32'(frames_sent), 32'd0);
        check("mid_reset_res_ready", 32'(res_ready), 32'd1);
        fr0 = frames_rx;
        push_val(16'hBEEF);
        wait_idle(300);
        check("post_reset_frame", last_frame, 32'hA5BE_EFF4);
        check("post_reset_count", 32'(frames_rx - fr0), 32'd1);
        check("post_reset_frames_sent", 32'(frames_sent), 32'd1);

        // Counter wrap: 256 frames, value = index
        do_reset();
        h_fixed = 0;
        csum_lo[8'hA5] = 8'hFF;
        fr0 = frames_rx;
        for (int i = 0; i < 256; i++) begin
            push_val(16'(i));
        end
        wait_idle(5000);
        check("wrap_frames_rx", 32'(frames_rx - fr0), 32'd256);
        check("wrap_frames_sent", 32'(frames_sent), 32'd0);
        check("wrap_csum_00a5", 32'(csum_lo[8'hA5]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
